// File: rtl/banked_dct_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : banked_dct_quantizer
//  Purpose  : Drains completed banks of 8x8 DCT coefficients from NUM_CHANNELS
//             parallel EBRs. Each coefficient is scaled by a per-index
//             reciprocal and then rounded and saturated. The results leave as
//             a valid/ready stream in zigzag or natural order.
//  Revision : 1.0 - initial release
// ============================================================================
module banked_dct_quantizer #(
    parameter int NUM_CHANNELS = 5,
    parameter int CH_BITS      = 3,
    parameter int COEFF_WIDTH  = 16,
    parameter int BANK_BITS    = 2,
    parameter int OUT_WIDTH    = 12
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [BANK_BITS-1:0]                prod_bank,
    output logic [BANK_BITS-1:0]                cons_bank,
    output logic                                bank_release,
    output logic [BANK_BITS+5:0]                rd_addr,
    input  logic [NUM_CHANNELS*COEFF_WIDTH-1:0] rd_data,
    input  logic                                zigzag_en,
    input  logic                                tbl_wr_en,
    input  logic [5:0]                          tbl_wr_addr,
    input  logic [15:0]                         tbl_wr_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OUT_WIDTH-1:0]         out_data,
    output logic [CH_BITS-1:0]                  out_channel,
    output logic [5:0]                          out_index,
    output logic                                out_last,
    output logic                                busy,
    output logic                                sat_flag,
    output logic                                overrun_flag,
    input  logic                                status_clear
);

    // Product width: signed coefficient times a zero-extended 16-bit reciprocal
    localparam int c_PW = COEFF_WIDTH + 17;
    localparam logic [CH_BITS-1:0]     c_LAST_CH = CH_BITS'(NUM_CHANNELS - 1);
    localparam logic signed [c_PW-1:0] c_RND     = c_PW'(32768);
    localparam logic signed [c_PW-1:0] c_SAT_HI  = c_PW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [c_PW-1:0] c_SAT_LO  = -c_SAT_HI - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Zigzag scan position -> natural (row-major) index when zz is set
    function automatic logic [5:0] f_map(input logic [5:0] pos, input logic zz);
        logic [5:0] z;
        z = pos;
        if (zz) begin
            case (pos)
                6'd0:  z = 6'd0;  6'd1:  z = 6'd1;  6'd2:  z = 6'd8;  6'd3:  z = 6'd16;
                6'd4:  z = 6'd9;  6'd5:  z = 6'd2;  6'd6:  z = 6'd3;  6'd7:  z = 6'd10;
                6'd8:  z = 6'd17; 6'd9:  z = 6'd24; 6'd10: z = 6'd32; 6'd11: z = 6'd25;
                6'd12: z = 6'd18; 6'd13: z = 6'd11; 6'd14: z = 6'd4;  6'd15: z = 6'd5;
                6'd16: z = 6'd12; 6'd17: z = 6'd19; 6'd18: z = 6'd26; 6'd19: z = 6'd33;
                6'd20: z = 6'd40; 6'd21: z = 6'd48; 6'd22: z = 6'd41; 6'd23: z = 6'd34;
                6'd24: z = 6'd27; 6'd25: z = 6'd20; 6'd26: z = 6'd13; 6'd27: z = 6'd6;
                6'd28: z = 6'd7;  6'd29: z = 6'd14; 6'd30: z = 6'd21; 6'd31: z = 6'd28;
                6'd32: z = 6'd35; 6'd33: z = 6'd42; 6'd34: z = 6'd49; 6'd35: z = 6'd56;
                6'd36: z = 6'd57; 6'd37: z = 6'd50; 6'd38: z = 6'd43; 6'd39: z = 6'd36;
                6'd40: z = 6'd29; 6'd41: z = 6'd22; 6'd42: z = 6'd15; 6'd43: z = 6'd23;
                6'd44: z = 6'd30; 6'd45: z = 6'd37; 6'd46: z = 6'd44; 6'd47: z = 6'd51;
                6'd48: z = 6'd58; 6'd49: z = 6'd59; 6'd50: z = 6'd52; 6'd51: z = 6'd45;
                6'd52: z = 6'd38; 6'd53: z = 6'd31; 6'd54: z = 6'd39; 6'd55: z = 6'd46;
                6'd56: z = 6'd53; 6'd57: z = 6'd60; 6'd58: z = 6'd61; 6'd59: z = 6'd54;
                6'd60: z = 6'd47; 6'd61: z = 6'd55; 6'd62: z = 6'd62; 6'd63: z = 6'd63;
            endcase
        end
        return z;
    endfunction

    // S0: issue counters for the coefficient currently on rd_addr
    logic                   zz_q;
    logic [CH_BITS-1:0]     ch_q;
    logic [5:0]             idx_q;
    logic [5:0]             nat_q;
    logic                   s0_v_q;
    logic [BANK_BITS+5:0]   rd_addr_q;
    // S1: metadata aligned with the EBR output word
    logic                   s1_v_q;
    logic [CH_BITS-1:0]     s1_ch_q;
    logic [5:0]             s1_idx_q;
    logic [5:0]             s1_nat_q;
    logic                   s1_last_q;
    logic [COEFF_WIDTH-1:0] hold_q;
    logic                   hold_v_q;
    // S2: product register
    logic                   s2_v_q;
    logic [CH_BITS-1:0]     s2_ch_q;
    logic [5:0]             s2_idx_q;
    logic                   s2_last_q;
    logic signed [c_PW-1:0] s2_prod_q;
    // S3: output register
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic [CH_BITS-1:0]     out_channel_q;
    logic [5:0]             out_index_q;
    logic                   out_last_q;
    // Control / status
    logic [BANK_BITS-1:0]   cons_bank_q;
    logic [BANK_BITS-1:0]   prod_prev_q;
    logic                   bank_release_q;
    logic                   sat_q;
    logic                   ovr_q;
    logic [15:0]            tbl_q [64];

    logic                   w_stall, w_start, w_issue_last, w_done;
    logic [5:0]             w_idx_nx, w_nat_nx;
    logic [COEFF_WIDTH-1:0] w_sel, w_coeff;
    logic [15:0]            w_recip;
    logic signed [c_PW-1:0] w_a, w_b, w_prod, w_sum, w_r;
    logic                   w_clip;
    logic [OUT_WIDTH-1:0]   w_qout;

    assign w_stall      = out_valid_q && !out_ready;
    assign w_start      = (state_q == ST_IDLE) && (prod_bank != cons_bank_q);
    assign w_issue_last = (ch_q == c_LAST_CH) && (idx_q == 6'd63);
    assign w_done       = (state_q == ST_DRAIN) && out_valid_q && out_ready && out_last_q;
    assign w_idx_nx     = idx_q + 6'd1;
    assign w_nat_nx     = f_map(w_idx_nx, zz_q);

    // Channel select from the shared EBR word
    always_comb begin
        w_sel = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (s1_ch_q == CH_BITS'(c)) begin
                w_sel = rd_data[c*COEFF_WIDTH +: COEFF_WIDTH];
            end
        end
    end

    // Multiply, round half toward +inf, saturate. While stalled the EBR has
    // already moved on to the held rd_addr, so S1 uses the word captured on
    // the first stalled edge.
    always_comb begin
        w_coeff = hold_v_q ? hold_q : w_sel;
        w_recip = tbl_q[s1_nat_q];
        w_a     = {{(c_PW-COEFF_WIDTH){w_coeff[COEFF_WIDTH-1]}}, w_coeff};
        w_b     = {{(c_PW-16){1'b0}}, w_recip};
        w_prod  = w_a * w_b;
        w_sum   = s2_prod_q + c_RND;
        w_r     = w_sum >>> 16;
        w_clip  = 1'b1;
        if (w_r > c_SAT_HI) begin
            w_qout = c_SAT_HI[OUT_WIDTH-1:0];
        end else if (w_r < c_SAT_LO) begin
            w_qout = c_SAT_LO[OUT_WIDTH-1:0];
        end else begin
            w_qout = w_r[OUT_WIDTH-1:0];
            w_clip = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_start) state_d = ST_RUN;
            ST_RUN:   if (!w_stall && w_issue_last) state_d = ST_DRAIN;
            ST_DRAIN: if (w_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address generation: one coefficient issued per unstalled RUN cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            zz_q      <= 1'b0;
            ch_q      <= '0;
            idx_q     <= '0;
            nat_q     <= '0;
            s0_v_q    <= 1'b0;
            rd_addr_q <= '0;
        end else if (w_start) begin
            zz_q      <= zigzag_en;
            ch_q      <= '0;
            idx_q     <= '0;
            nat_q     <= f_map(6'd0, zigzag_en);
            s0_v_q    <= 1'b1;
            rd_addr_q <= {cons_bank_q, f_map(6'd0, zigzag_en)};
        end else if (state_q == ST_RUN && !w_stall) begin
            if (w_issue_last) begin
                s0_v_q <= 1'b0;
            end else begin
                idx_q     <= w_idx_nx;
                nat_q     <= w_nat_nx;
                rd_addr_q <= {cons_bank_q, w_nat_nx};
                if (idx_q == 6'd63) ch_q <= ch_q + CH_BITS'(1);
            end
        end
    end

    // Pipeline S1..S3; every stage freezes while the output is back-pressured
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v_q <= 1'b0; s1_ch_q <= '0; s1_idx_q <= '0; s1_nat_q <= '0; s1_last_q <= 1'b0;
            hold_q <= '0;   hold_v_q <= 1'b0;
            s2_v_q <= 1'b0; s2_ch_q <= '0; s2_idx_q <= '0; s2_last_q <= 1'b0; s2_prod_q <= '0;
            out_valid_q <= 1'b0; out_data_q <= '0; out_channel_q <= '0;
            out_index_q <= '0;   out_last_q <= 1'b0;
        end else if (!w_stall) begin
            s1_v_q        <= s0_v_q;
            s1_ch_q       <= ch_q;
            s1_idx_q      <= idx_q;
            s1_nat_q      <= nat_q;
            s1_last_q     <= w_issue_last;
            hold_v_q      <= 1'b0;
            s2_v_q        <= s1_v_q;
            s2_ch_q       <= s1_ch_q;
            s2_idx_q      <= s1_idx_q;
            s2_last_q     <= s1_last_q;
            s2_prod_q     <= w_prod;
            out_valid_q   <= s2_v_q;
            out_data_q    <= w_qout;
            out_channel_q <= s2_ch_q;
            out_index_q   <= s2_idx_q;
            out_last_q    <= s2_last_q;
        end else if (!hold_v_q) begin
            hold_q   <= w_sel;
            hold_v_q <= 1'b1;
        end
    end

    // Reciprocal table; only writable while the pipeline is idle
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) tbl_q[i] <= 16'd4096;
        end else if (tbl_wr_en && state_q == ST_IDLE) begin
            tbl_q[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Bank hand-off and sticky status flags (a set event beats a clear)
    always_ff @(posedge clock) begin
        if (reset) begin
            cons_bank_q    <= '0;
            prod_prev_q    <= '0;
            bank_release_q <= 1'b0;
            sat_q          <= 1'b0;
            ovr_q          <= 1'b0;
        end else begin
            prod_prev_q    <= prod_bank;
            bank_release_q <= w_done;
            if (w_done) cons_bank_q <= cons_bank_q + BANK_BITS'(1);
            if (!w_stall && s2_v_q && w_clip) sat_q <= 1'b1;
            else if (status_clear)            sat_q <= 1'b0;
            if ((prod_bank != prod_prev_q) && (prod_bank == cons_bank_q) && busy) ovr_q <= 1'b1;
            else if (status_clear)                                                ovr_q <= 1'b0;
        end
    end

    assign cons_bank    = cons_bank_q;
    assign bank_release = bank_release_q;
    assign rd_addr      = rd_addr_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_channel  = out_channel_q;
    assign out_index    = out_index_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q != ST_IDLE);
    assign sat_flag     = sat_q;
    assign overrun_flag = ovr_q;

endmodule
`default_nettype wire

// File: doc/banked_dct_quantizer.md
Name: banked_dct_quantizer

Overview:
Consumes completed banks of 8x8 DCT coefficients from NUM_CHANNELS parallel 16-bit coefficient EBRs sharing one read address. Each coefficient is quantised by multiplying with a per-index reciprocal table, then rounded and saturated. Coefficients are emitted as a valid/ready stream in zigzag or natural order. It sits between the DCT engines' banked output memories and the entropy coder, and generalises the fixed 5-engine, 4-bank quantizer.

Parameters:
NUM_CHANNELS, 5, number of DCT output EBRs (blocks per bank)
CH_BITS, 3, width of out_channel; must satisfy 2^CH_BITS >= NUM_CHANNELS
COEFF_WIDTH, 16, signed coefficient width in EBR
BANK_BITS, 2, log2 of bank count; EBR address = {bank, 6-bit coeff index}
OUT_WIDTH, 12, signed quantised output width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
prod_bank  in  BANK_BITS  producer bank pointer; banks below it (mod 2^BANK_BITS) are complete
cons_bank  out  BANK_BITS  bank currently being or next to be consumed
bank_release  out  1  one-cycle pulse when cons_bank advances
rd_addr  out  BANK_BITS+6  registered EBR read address, common to all channels
rd_data  in  NUM_CHANNELS*COEFF_WIDTH  channel c at [c*COEFF_WIDTH +: COEFF_WIDTH]; 1-cycle EBR latency
zigzag_en  in  1  1 = zigzag order, 0 = natural order; sampled on IDLE->RUN
tbl_wr_en  in  1  reciprocal table write strobe
tbl_wr_addr  in  6  natural coefficient index
tbl_wr_data  in  16  unsigned reciprocal, round(65536/q)
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accept
out_data  out  OUT_WIDTH  signed quantised coefficient
out_channel  out  CH_BITS  source channel
out_index  out  6  position in emitted order (0..63)
out_last  out  1  last coefficient of last channel in the bank
busy  out  1  FSM not IDLE
sat_flag  out  1  sticky; a result saturated
overrun_flag  out  1  sticky; producer lapped consumer
status_clear  in  1  clears sat_flag and overrun_flag

Behaviour:
- Reset values: cons_bank=0, rd_addr=0, out_valid=0, out_data=0, out_channel=0, out_index=0, out_last=0, bank_release=0, busy=0, both flags=0. All 64 table entries reset to 4096 (q=16).
- Reset mid-bank abandons the bank. All pipeline valids clear. Nothing further is emitted.
- FSM IDLE:
  - If prod_bank != cons_bank: go to RUN.
  - On entry: latch zigzag_en; channel=0, idx=0; set rd_addr={cons_bank, map(0)}.
- FSM RUN:
  - Each unstalled cycle, advance idx. At idx 63, wrap to 0 and increment channel.
  - After issuing channel NUM_CHANNELS-1 idx 63, go to DRAIN.
- FSM DRAIN:
  - When the out_last beat is accepted: cons_bank += 1 (wraps), pulse bank_release, go to IDLE.
  - If prod_bank != new cons_bank, re-enter RUN after one IDLE cycle.
- map(idx): standard JPEG zigzag (0,1,8,16,9,2,3,10,17,24,...,63) when latched zigzag_en=1; otherwise identity.
- Pipeline stages: S0 addr register -> S1 EBR data + channel select -> S2 multiply register -> S3 output register.
  - First out_valid appears on the 3rd rising edge after the edge that leaves IDLE.
  - Throughput: 1 coefficient/cycle with out_ready=1.
- Stall: whenever out_valid && !out_ready, all stages and rd_addr hold. Output fields stay stable. Holding rd_addr keeps the EBR re-reading the same data.
- Arithmetic:
  - p = signed(coeff) * {1'b0, recip}; recip = table[natural index].
  - r = (p + 32768) >>> 16: round half toward +inf.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; any clipping sets sat_flag.
- Table writes:
  - Accepted only while IDLE. Writes in any other state are dropped.
  - A write that coincides with the IDLE->RUN transition is accepted.
- overrun_flag: set when prod_bank changes to a value equal to cons_bank while busy.
- status_clear: clears both flags. A simultaneous set event wins.
- out_last = 1 only on channel NUM_CHANNELS-1, out_index 63.

Test Plan:
- Reset, default table, bank 0 all channels coeff=1000, prod_bank 0->1, out_ready=1, zigzag_en=1 -> 320 beats, all out_data=63; out_last on beat 320; bank_release pulses once; cons_bank=1; first out_valid 3 edges after RUN entry.
- Coeff at natural index 8 = 160, others 0, zigzag_en=1 -> nonzero out_data=10 at out_index 2 in every channel; with zigzag_en=0 it appears at out_index 8.
- Rounding, recip 4096: coeff 8 -> 1; coeff -8 -> 0; coeff -24 -> -1. Saturation: coeff 32767 with recip 65535 -> out_data 2047 and sat_flag=1; status_clear -> 0.
- Random out_ready (~50%) -> beat sequence identical to the ready=1 run; fields constant during every stall.
- prod_bank advanced by 3 in one step -> three banks processed back-to-back; cons_bank wraps 3->0; three bank_release pulses. Then prod_bank advanced by 4 (= cons_bank) while busy -> overrun_flag=1.
- tbl_wr_en during RUN with data 1 -> table unchanged, outputs unaffected. Assert reset mid-bank -> out_valid=0 next cycle, cons_bank=0, busy=0.
